// File: rtl/pixel_readout_pkg.sv
// pixel_readout_pkg: state encoding and index-width helper shared by the readout controller.
// Contents: state_t (IDLE, SETTLE, CAPTURE, STREAM, DONE) and idx_w(n), the width of an
// index that counts 0..n-1. idx_w never returns less than 1, so 1-row or 1-column arrays
// still get a real counter.
package pixel_readout_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, STREAM, DONE} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pixel_readout_if.sv
// pixel_readout_if: valid/ready pixel word stream from the readout controller to the frame buffer.
// Signals: out_valid, out_data[DATA_W], out_row[idx_w(N_ROWS)] and out_col[idx_w(N_COLS)]
// are driven by the master. out_ready is driven by the slave.
interface pixel_readout_if import pixel_readout_pkg::*; #(
  parameter int N_ROWS = 2,
  parameter int N_COLS = 2,
  parameter int DATA_W = 8
);
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_data;
  logic [idx_w(N_ROWS)-1:0] out_row;
  logic [idx_w(N_COLS)-1:0] out_col;
  modport master(output out_valid, out_data, out_row, out_col, input out_ready);
  modport slave(input out_valid, out_data, out_row, out_col, output out_ready);
endinterface

// File: rtl/pixel_readout_mux.sv
// pixel_readout_mux: holds one captured row of column ADC words and selects one word by column.
// Ports:
//   clk, reset - clock and synchronous active-low reset; reset clears the capture register.
//   load       - latches col_data into the capture register.
//   col_data   - N_COLS*DATA_W input; column c occupies bits [c*DATA_W +: DATA_W].
//   sel        - column index.
//   word       - DATA_W output, the selected word of the capture register.
module pixel_readout_mux #(
  parameter int N_COLS = 2,
  parameter int DATA_W = 8,
  parameter int CW = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic [N_COLS*DATA_W-1:0] col_data,
  input  logic [CW-1:0] sel,
  output logic [DATA_W-1:0] word
);
  logic [N_COLS-1:0][DATA_W-1:0] cap;
  always_ff @(posedge clk)
    if (!reset) cap <= '0;
    else if (load) cap <= col_data;
  assign word = cap[sel];
endmodule

// File: rtl/pixel_readout_ctrl.sv
// pixel_readout_ctrl: walks the pixel array row by row (settle, capture, stream) and signals the end of a pass.
// Ports:
//   clk, reset - clock and synchronous active-low reset.
//   start      - requests a readout pass. It is sampled only in IDLE.
//   col_data   - column ADC words from the array.
//   row_sel    - one-hot row select. It is high in SETTLE and CAPTURE.
//   bus        - pixel_readout_if master: the word stream with its row and column.
//   busy       - high in every state except IDLE.
//   done       - one-cycle pulse after the last word is accepted.
//   overrun    - sticky flag. It is set when start arrives while busy.
//   timeout    - present only with PIXEL_READOUT_TIMEOUT_EN. It pulses when a stalled stream is aborted.
// The optional stall timeout is compiled in by defining PIXEL_READOUT_TIMEOUT_EN.
module pixel_readout_ctrl import pixel_readout_pkg::*; #(
  parameter int N_ROWS = 2,
  parameter int N_COLS = 2,
  parameter int DATA_W = 8,
  parameter int SETTLE_CYC = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [N_COLS*DATA_W-1:0] col_data,
  output logic [N_ROWS-1:0] row_sel,
  pixel_readout_if.master bus,
  output logic busy,
  output logic done,
  output logic overrun
`ifdef PIXEL_READOUT_TIMEOUT_EN
  ,
  output logic timeout
`endif
);
  localparam int RW = idx_w(N_ROWS);
  localparam int CW = idx_w(N_COLS);
  localparam int SW = idx_w(SETTLE_CYC);
  if (N_ROWS < 1 || N_COLS < 1 || SETTLE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("pixel_readout_ctrl: N_ROWS, N_COLS, SETTLE_CYC and TIMEOUT_CYC must be >= 1");
  end
  state_t state, state_n;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] col_idx;
  logic [SW-1:0] settle_cnt;
  logic xfer, last_col, last_row, abort;
  assign xfer = state == STREAM && bus.out_ready;
  assign last_col = col_idx == CW'(N_COLS - 1);
  assign last_row = row_idx == RW'(N_ROWS - 1);
`ifdef PIXEL_READOUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] stall_cnt;
  // Abort on the TIMEOUT_CYC-th consecutive stalled cycle. The pass is in IDLE, with timeout high, one cycle later.
  assign abort = state == STREAM && !bus.out_ready && stall_cnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    if (!reset) begin
      stall_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= abort;
      stall_cnt <= (state == STREAM && !bus.out_ready && !abort) ? stall_cnt + 1'b1 : '0;
    end
`else
  assign abort = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      overrun <= overrun | (start && state != IDLE);
    end
  always_comb begin
    state_n = state == IDLE ? (start ? SETTLE : IDLE)
            : state == SETTLE ? (settle_cnt == '0 ? CAPTURE : SETTLE)
            : state == CAPTURE ? STREAM
            : state == STREAM ? (abort ? IDLE : (xfer && last_col) ? (last_row ? DONE : SETTLE) : STREAM)
            : IDLE;
    row_sel = (state == SETTLE || state == CAPTURE) ? N_ROWS'(1) << row_idx : '0;
    busy = state != IDLE;
    done = state == DONE;
    bus.out_valid = state == STREAM;
    bus.out_row = row_idx;
    bus.out_col = col_idx;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      row_idx <= '0;
      col_idx <= '0;
      settle_cnt <= '0;
    end else begin
      if (state == IDLE && start) begin
        row_idx <= '0;
        settle_cnt <= SW'(SETTLE_CYC - 1);
      end else if (state == SETTLE) settle_cnt <= settle_cnt - 1'b1;
      if (state == CAPTURE) col_idx <= '0;
      if (xfer && !last_col) col_idx <= col_idx + 1'b1;
      // Moving to the next row reloads the settle counter for its SETTLE phase.
      if (xfer && last_col && !last_row) begin
        row_idx <= row_idx + 1'b1;
        settle_cnt <= SW'(SETTLE_CYC - 1);
      end
    end
  pixel_readout_mux #(.N_COLS(N_COLS), .DATA_W(DATA_W), .CW(CW)) u_mux (
    .clk(clk),
    .reset(reset),
    .load(state == CAPTURE),
    .col_data(col_data),
    .sel(col_idx),
    .word(bus.out_data)
  );
endmodule
